// File: rtl/alu_pkg.sv
// Shared ALU opcodes and execute-unit FSM encoding.
// The opcode values are also consumed by the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

  function automatic shift_kind_e shift_kind(input logic [3:0] ctl);
    shift_kind_e k;
    case (ctl)
      ALU_SRL: k = SH_RL;
      ALU_SRA: k = SH_RA;
      default: k = SH_LL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// Serial one-bit-per-cycle shifter: loads source and amount, then shifts until the counter hits zero.
// shift_done pulses in the last shift cycle while shift_nxt carries the final value.
module alu_shift_serial
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  shift_kind_e        kind,
  input  logic [XLEN-1:0]    src,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               shift_done,
  output logic [XLEN-1:0]    shift_nxt
);

  logic [XLEN-1:0]    sr_q,   sr_d;
  logic [SHAMT_W-1:0] cnt_q,  cnt_d;
  shift_kind_e        kind_q, kind_d;
  logic               fill_q, fill_d;
  logic               fill_bit;

  always_comb begin
    fill_bit = (kind_q == SH_RA) ? fill_q : 1'b0;
    if (kind_q == SH_LL) begin
      shift_nxt = {sr_q[XLEN-2:0], 1'b0};
    end else begin
      shift_nxt = {fill_bit, sr_q[XLEN-1:1]};
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    fill_d = fill_q;
    if (load) begin
      sr_d   = src;
      cnt_d  = shamt;
      kind_d = kind;
      // Sign fill is captured once so SRA never depends on later operand changes.
      fill_d = src[XLEN-1];
    end else if (cnt_q != '0) begin
      sr_d  = shift_nxt;
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  assign shift_done = !load && (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
      fill_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: 1-cycle logic/arith ops, serial shifts (n+1 cycles), registered result and zero.
// Result is held in DONE for any length of out_ready backpressure; new requests only accepted in IDLE.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;
  logic [XLEN-1:0]    alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               op_is_shift;
  logic               shift_load;
  logic               shift_done;
  logic [XLEN-1:0]    shift_nxt;

  assign shamt       = op_b[SHAMT_W-1:0];
  assign accept      = (state_q == ST_IDLE) && in_valid;
  assign op_is_shift = is_shift(alu_ctl);
  assign shift_load  = accept && op_is_shift && (shamt != '0);

  alu_shift_serial #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (shift_load),
    .kind       (shift_kind(alu_ctl)),
    .src        (op_a),
    .shamt      (shamt),
    .shift_done (shift_done),
    .shift_nxt  (shift_nxt)
  );

  always_comb begin
    case (alu_ctl)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_res = op_a + op_b;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = shift_load ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result capture: only on accept of a non-serial op or on the final shift step.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    if (accept && !shift_load) begin
      result_d = op_is_shift ? op_a : alu_res;
      zero_d   = (result_d == '0);
    end else if ((state_q == ST_SHIFT) && shift_done) begin
      result_d = shift_nxt;
      zero_d   = (result_d == '0);
    end
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = result_q;
    zero      = zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops against a reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctl = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  function automatic logic [31:0] ref_result(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int n;
    sa = a;
    sb = b;
    n  = b % 32;
    case (ctl)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0100: return a << n;
      4'b0101: return a >> n;
      4'b1001: return sa >>> n;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] ctl, input logic [31:0] b);
    int n;
    n = b % 32;
    if ((ctl == 4'b0100 || ctl == 4'b0101 || ctl == 4'b1001) && n != 0) return n + 1;
    return 1;
  endfunction

  // Issue one request and wait (bounded) for out_valid; leaves the DUT in DONE with out_ready low.
  task automatic do_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic z);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    alu_ctl  = ctl;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctl  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    z   = zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_tests++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
  endtask

  task automatic test_arith();
    int lat; logic [31:0] res; logic z;
    do_op(4'b0110, 32'd5, 32'd5, lat, res, z);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL sub_latency got %0d want 1", lat); end
    n_tests++; if (res !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL sub_result got %h/%b want 0/1", res, z); end
    release_result();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_back_to_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, lat, res, z);
    n_tests++; if (res !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL add_wrap got %h/%b want 0/1", res, z); end
    release_result();
  endtask

  task automatic test_compare();
    int lat; logic [31:0] res; logic z;
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat, res, z);
    n_tests++; if (res !== 32'd1 || z !== 1'b0) begin n_fail++; $display("FAIL slt got %h/%b want 1/0", res, z); end
    release_result();
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd1, lat, res, z);
    n_tests++; if (res !== 32'd0 || z !== 1'b1) begin n_fail++; $display("FAIL sltu got %h/%b want 0/1", res, z); end
    release_result();
    do_op(4'b1111, 32'd3, 32'd4, lat, res, z);
    n_tests++; if (res !== 32'd7 || lat !== 1) begin n_fail++; $display("FAIL undef_add got %h lat %0d want 7 lat 1", res, lat); end
    release_result();
  endtask

  task automatic test_shift_directed();
    int lat; logic [31:0] res; logic z;
    do_op(4'b1001, 32'h8000_0000, 32'd31, lat, res, z);
    n_tests++; if (lat !== 32 || res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31 got %h lat %0d want ffffffff lat 32", res, lat); end
    release_result();
    do_op(4'b0101, 32'h8000_0000, 32'd31, lat, res, z);
    n_tests++; if (lat !== 32 || res !== 32'd1) begin n_fail++; $display("FAIL srl31 got %h lat %0d want 1 lat 32", res, lat); end
    release_result();
    do_op(4'b0100, 32'd1, 32'd0, lat, res, z);
    n_tests++; if (lat !== 1 || res !== 32'd1) begin n_fail++; $display("FAIL sll0 got %h lat %0d want 1 lat 1", res, lat); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; logic z;
    int bad;
    bad = 0;
    do_op(4'b0100, 32'd1, 32'd4, lat, res, z);
    n_tests++; if (lat !== 5 || res !== 32'h10) begin n_fail++; $display("FAIL bp_sll4 got %h lat %0d want 10 lat 5", res, lat); end
    for (int i = 0; i < 10; i++) begin
      if (result !== 32'h10 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) bad++;
      in_valid = 1'b1;
      alu_ctl  = 4'b0010;
      op_a     = 32'd7;
      op_b     = 32'd7;
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    int stale;
    stale = 0;
    @(negedge clk);
    alu_ctl  = 4'b0100;
    op_a     = 32'd1;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_shift_busy got rdy=%b vld=%b want 0/0", in_ready, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL mid_shift_reset got rdy=%b vld=%b res=%h z=%b want 1/0/0/1", in_ready, out_valid, result, zero);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || result !== 32'h0) stale++;
    end
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL mid_shift_stale got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic z;
    logic [3:0] ctl; logic [31:0] a, b, exp;
    for (int i = 0; i < 60; i++) begin
      ctl = 4'($urandom);
      a   = $urandom;
      b   = $urandom;
      if (i % 4 == 0) a = 32'h8000_0000 | a;
      if (i % 5 == 0) b = a;
      exp = ref_result(ctl, a, b);
      do_op(ctl, a, b, lat, res, z);
      n_tests++; if (res !== exp || z !== (exp == 32'h0)) begin
        n_fail++; $display("FAIL rand_result ctl=%b a=%h b=%h got %h/%b want %h/%b", ctl, a, b, res, z, exp, (exp == 32'h0));
      end
      n_tests++; if (lat !== ref_latency(ctl, b)) begin
        n_fail++; $display("FAIL rand_latency ctl=%b b=%h got %0d want %0d", ctl, b, lat, ref_latency(ctl, b));
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
